dcache: RTL



---
 rtl/dcache_pkg.sv | 19 +
 rtl/dcache_store.sv | 50 +++++
 rtl/dcache.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache: address field
// widths derived from the CPU address layout, and the controller state encoding.
package dcache_pkg;

  localparam int ADDR_W   = 8;
  localparam int INDEX_W  = 3;
  localparam int OFFSET_W = 2;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int BLOCK_W  = 8 << OFFSET_W;
  localparam int LINES    = 1 << INDEX_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FETCH,
    UPDATE
  } state_t;

endpackage

// File: rtl/dcache_store.sv
// Line storage for the data cache: valid/dirty/tag/data arrays with a
// combinational read port and a single synchronous whole-line write port.
module dcache_store
  import dcache_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [BLOCK_W-1:0] rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic               wr_valid,
  input  logic               wr_dirty,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [BLOCK_W-1:0] wr_data
);

  logic [LINES-1:0]   valid;
  logic [LINES-1:0]   dirty;
  logic [TAG_W-1:0]   tags  [LINES];
  logic [BLOCK_W-1:0] blocks[LINES];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      dirty <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= wr_valid;
      dirty[wr_index] <= wr_dirty;
    end
  end

  // NOTE: tag and data arrays carry no reset; their content is meaningless
  // while valid is clear, so they can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index]   <= wr_tag;
      blocks[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_dirty = dirty[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = blocks[rd_index];

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache: CPU byte interface on
// one side, block-wide memory interface on the other, miss FSM in between.
module dcache
  import dcache_pkg::*;
(
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       READ,
  input  logic                       WRITE,
  input  logic [ADDR_W-1:0]          ADDRESS,
  input  logic [7:0]                 WRITEDATA,
  output logic [7:0]                 READDATA,
  output logic                       BUSYWAIT,
  output logic                       MEM_READ,
  output logic                       MEM_WRITE,
  output logic [ADDR_W-OFFSET_W-1:0] MEM_ADDRESS,
  output logic [BLOCK_W-1:0]         MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0]         MEM_READDATA,
  input  logic                       MEM_BUSYWAIT
);

  state_t             state, state_next;
  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_index;
  logic [BLOCK_W-1:0] fill_data;
  logic [7:0]         readdata_q;

  logic [TAG_W-1:0]    addr_tag;
  logic [INDEX_W-1:0]  addr_index;
  logic [OFFSET_W-1:0] addr_offset;
  logic [INDEX_W-1:0]  rd_index;
  logic                rd_valid, rd_dirty;
  logic [TAG_W-1:0]    rd_tag;
  logic [BLOCK_W-1:0]  rd_data;
  logic                wr_en, wr_valid, wr_dirty;
  logic [TAG_W-1:0]    wr_tag;
  logic [BLOCK_W-1:0]  wr_data;
  logic                request, hit, read_hit;
  logic [7:0]          sel_byte;

  assign addr_tag    = ADDRESS[ADDR_W-1 -: TAG_W];
  assign addr_index  = ADDRESS[OFFSET_W +: INDEX_W];
  assign addr_offset = ADDRESS[OFFSET_W-1:0];

  // Outside IDLE the CPU address is not trusted; the latched miss index is used.
  assign rd_index = (state == IDLE) ? addr_index : req_index;
  assign request  = READ | WRITE;
  assign hit      = rd_valid && (rd_tag == addr_tag);
  assign sel_byte = rd_data[{addr_offset, 3'b000} +: 8];
  assign read_hit = (state == IDLE) && READ && !WRITE && hit;
  assign READDATA = read_hit ? sel_byte : readdata_q;

  dcache_store u_store (
    .clk      (CLK),
    .reset    (RESET),
    .rd_index (rd_index),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_index (rd_index),
    .wr_valid (wr_valid),
    .wr_dirty (wr_dirty),
    .wr_tag   (wr_tag),
    .wr_data  (wr_data)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      req_tag    <= '0;
      req_index  <= '0;
      fill_data  <= '0;
      readdata_q <= '0;
    end else begin
      state <= state_next;
      if (read_hit) readdata_q <= sel_byte;
      if (state == IDLE && request && !hit) begin
        req_tag   <= addr_tag;
        req_index <= addr_index;
      end
      if (state == FETCH && !MEM_BUSYWAIT) fill_data <= MEM_READDATA;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    state_next    = state;
    BUSYWAIT      = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = {req_tag, req_index};
    MEM_WRITEDATA = rd_data;
    wr_en         = 1'b0;
    wr_valid      = rd_valid;
    wr_dirty      = rd_dirty;
    wr_tag        = rd_tag;
    wr_data       = rd_data;
    case (state)
      IDLE: begin
        if (request) begin
          if (hit) begin
            if (WRITE) begin
              wr_en    = 1'b1;
              wr_dirty = 1'b1;
              wr_data[{addr_offset, 3'b000} +: 8] = WRITEDATA;
            end
          end else begin
            BUSYWAIT   = 1'b1;
            state_next = (rd_valid && rd_dirty) ? WRITEBACK : FETCH;
          end
        end
      end
      WRITEBACK: begin
        BUSYWAIT    = 1'b1;
        MEM_WRITE   = 1'b1;
        MEM_ADDRESS = {rd_tag, req_index};
        if (!MEM_BUSYWAIT) begin
          wr_en      = 1'b1;
          wr_dirty   = 1'b0;
          state_next = FETCH;
        end
      end
      FETCH: begin
        BUSYWAIT = 1'b1;
        MEM_READ = 1'b1;
        if (!MEM_BUSYWAIT) state_next = UPDATE;
      end
      UPDATE: begin
        BUSYWAIT   = 1'b1;
        wr_en      = 1'b1;
        wr_valid   = 1'b1;
        wr_dirty   = 1'b0;
        wr_tag     = req_tag;
        wr_data    = fill_data;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
